// File: rtl/calendar_pkg.sv
// Shared display constants and the BCD-to-7-segment decode for the calendar project.
// Segment codes are active-high {g,f,e,d,c,b,a}; the driver applies pin polarity afterwards.
package calendar_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [6:0]            SEG_OFF = 7'h00;
  localparam logic [MAX_DIGITS-1:0] AN_OFF  = '0;

  // Malformed BCD shows a dash rather than a plausible-looking digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser with a history flop; gives the resampled level and a
// one-cycle pulse on each rising edge.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-anode 7-segment display: scans digits on
// scan_clk edges, blanks briefly after each switch, and supports blink/blank masks.
module seg_scan_driver
  import calendar_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned SEG_ACT_LOW  = 1,
  parameter int unsigned AN_ACT_LOW   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          scan_clk_i,
  input  logic                          blink_clk_i,
  input  logic [4*NUM_DIGITS-1:0]       digits_bcd_i,
  input  logic [NUM_DIGITS-1:0]         dp_mask_i,
  input  logic [NUM_DIGITS-1:0]         blink_mask_i,
  input  logic [NUM_DIGITS-1:0]         blank_mask_i,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [6:0]                    seg_o,
  output logic                          dp_o,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx_o
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned GuardW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [NUM_DIGITS-1:0] AnOff    = AN_OFF[NUM_DIGITS-1:0];
  localparam logic [NUM_DIGITS-1:0] AnInact  = (AN_ACT_LOW != 0) ? ~AnOff : AnOff;
  localparam logic [6:0]            SegInact = (SEG_ACT_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DpInact  = (SEG_ACT_LOW != 0);

  logic scan_tick, blink_lvl, blink_rise_unused, scan_lvl_unused;

  edge_sync u_scan_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (scan_clk_i),
    .level_o (scan_lvl_unused),
    .rise_o  (scan_tick)
  );

  edge_sync u_blink_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (blink_clk_i),
    .level_o (blink_lvl),
    .rise_o  (blink_rise_unused)
  );

  logic [IdxW-1:0]       idx_q, idx_d;
  logic [GuardW-1:0]     guard_q, guard_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, an_hi;
  logic [6:0]            seg_q, seg_d, seg_hi;
  logic                  dp_q, dp_d, dp_hi;
  logic [3:0]            digit;
  logic                  dark;

  always_comb begin
    idx_d   = idx_q;
    guard_d = guard_q;
    if (scan_tick) begin
      idx_d   = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      guard_d = GuardW'(BLANK_CYCLES);
    end else if (guard_q != '0) begin
      guard_d = guard_q - 1'b1;
    end
  end

  // Outputs follow the current-cycle index/guard, so they lag scan_idx by one clock.
  always_comb begin
    digit  = digits_bcd_i[4*idx_q +: 4];
    dark   = (guard_q != '0) | blank_mask_i[idx_q] | (blink_mask_i[idx_q] & blink_lvl);
    an_hi  = AnOff;
    seg_hi = SEG_OFF;
    dp_hi  = 1'b0;
    if (!dark) begin
      an_hi[idx_q] = 1'b1;
      seg_hi       = bcd_to_seg(digit);
      dp_hi        = dp_mask_i[idx_q];
    end
    an_d  = (AN_ACT_LOW != 0) ? ~an_hi : an_hi;
    seg_d = (SEG_ACT_LOW != 0) ? ~seg_hi : seg_hi;
    dp_d  = (SEG_ACT_LOW != 0) ? ~dp_hi : dp_hi;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      guard_q <= '0;
      an_q    <= AnInact;
      seg_q   <= SegInact;
      dp_q    <= DpInact;
    end else begin
      idx_q   <= idx_d;
      guard_q <= guard_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an_o       = an_q;
  assign seg_o      = seg_q;
  assign dp_o       = dp_q;
  assign scan_idx_o = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (8 digits, 4 blanking cycles, active-low pins);
// expected outputs are queued per cycle and compared after each clock edge.
module tb_seg_scan_driver;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_clk = 1'b0;
  logic        blink_clk = 1'b0;
  logic [31:0] digits = 32'h76543210;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  blink_mask = 8'h00;
  logic [7:0]  blank_mask = 8'h00;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  scan_idx;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS   (8),
    .BLANK_CYCLES (4),
    .SEG_ACT_LOW  (1),
    .AN_ACT_LOW   (1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scan_clk_i   (scan_clk),
    .blink_clk_i  (blink_clk),
    .digits_bcd_i (digits),
    .dp_mask_i    (dp_mask),
    .blink_mask_i (blink_mask),
    .blank_mask_i (blank_mask),
    .an_o         (an),
    .seg_o        (seg),
    .dp_o         (dp),
    .scan_idx_o   (scan_idx)
  );

  function automatic obs_t dark(int idx);
    obs_t e;
    e.idx = 3'(idx);
    e.an  = 8'hFF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    return e;
  endfunction

  // Output expected when digit k is selected and not in its blanking window.
  function automatic obs_t disp(int k, int idx);
    obs_t       e;
    logic [7:0] a;
    if (blank_mask[k]) return dark(idx);
    a     = 8'd1 << k;
    e.idx = 3'(idx);
    e.an  = ~a;
    e.seg = ~TBL[digits[4*k +: 4]];
    e.dp  = ~dp_mask[k];
    return e;
  endfunction

  task automatic step(input string tag, input obs_t e);
    obs_t  o, x;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    o = {scan_idx, an, seg, dp};
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    n_checks++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed idx=%0d an=%h seg=%h dp=%b, expected idx=%0d an=%h seg=%h dp=%b",
             t, o.idx, o.an, o.seg, o.dp, x.idx, x.an, x.seg, x.dp);
    end
  endtask

  // One scan_clk pulse: idx moves on the third edge, then four dark cycles.
  task automatic scan_step(input string tag, input int k_old, input int k_new);
    scan_clk = 1'b1;
    step(tag, disp(k_old, k_old));
    step(tag, disp(k_old, k_old));
    step(tag, disp(k_old, k_new));
    scan_clk = 1'b0;
    repeat (4) step(tag, dark(k_new));
    step(tag, disp(k_new, k_new));
  endtask

  always @(negedge clk) begin
    logic [7:0] act;
    act = ~an;
    n_checks++;
    assert ($countones(act) <= 1) else begin
      n_fail++;
      $error("FAIL onehot: observed an=%h, expected at most one active anode", an);
    end
  end

  initial begin
    // Reset
    repeat (3) step("reset", dark(0));
    rst = 1'b0;
    step("reset_release", disp(0, 0));

    // Scan and wrap: 0 -> 1..7,0,1,2
    for (int i = 0; i < 10; i++) scan_step("scan_wrap", i % 8, (i + 1) % 8);

    // Tick timing and a stuck-high scan_clk
    scan_clk = 1'b1;
    step("tick_n", disp(2, 2));
    step("tick_n1", disp(2, 2));
    step("tick_n2", disp(2, 3));
    for (int i = 0; i < 997; i++) step("scan_stuck", (i < 4) ? dark(3) : disp(3, 3));
    scan_clk = 1'b0;
    repeat (4) step("scan_low", disp(3, 3));
    for (int i = 3; i < 8; i++) scan_step("to_digit0", i, (i + 1) % 8);

    // Blink on digit 0
    blink_mask = 8'h01;
    step("blink_off_phase0", disp(0, 0));
    blink_clk = 1'b1;
    step("blink_sync1", disp(0, 0));
    step("blink_sync2", disp(0, 0));
    step("blink_dark", dark(0));
    step("blink_dark", dark(0));
    blink_clk = 1'b0;
    step("blink_dark_sync", dark(0));
    step("blink_dark_sync", dark(0));
    step("blink_lit", disp(0, 0));

    // Scan tick and blink edge together
    scan_clk  = 1'b1;
    blink_clk = 1'b1;
    step("tick_blink", disp(0, 0));
    step("tick_blink", disp(0, 0));
    step("tick_blink_dark", dark(1));
    scan_clk = 1'b0;
    repeat (4) step("tick_blink_guard", dark(1));
    step("tick_blink_d1_lit", disp(1, 1));
    blink_mask = 8'h02;
    step("blink_d1", dark(1));
    blink_clk = 1'b0;
    step("blink_d1_sync", dark(1));
    step("blink_d1_sync", dark(1));
    step("blink_d1_lit", disp(1, 1));
    blink_mask = 8'h00;

    // Permanent blank on digit 1 across a full scan cycle
    blank_mask = 8'h02;
    repeat (3) step("blank_d1", dark(1));
    for (int i = 0; i < 9; i++) scan_step("blank_cycle", (1 + i) % 8, (2 + i) % 8);
    blank_mask = 8'h00;

    // Decode and decimal point on digit 0
    for (int i = 2; i < 8; i++) scan_step("to_digit0b", i, (i + 1) % 8);
    digits[3:0] = 4'hA;
    dp_mask     = 8'h01;
    step("decode_dash_dp", '{idx: 3'd0, an: 8'hFE, seg: 7'h3F, dp: 1'b0});
    for (int v = 0; v < 16; v++) begin
      digits[3:0] = 4'(v);
      step("decode_sweep", disp(0, 0));
    end
    digits[3:0] = 4'h0;
    scan_step("dp_digit0_only", 0, 1);

    // Reset mid-operation at idx=5, guard=2
    for (int i = 1; i < 4; i++) scan_step("to_digit4", i, i + 1);
    scan_clk = 1'b1;
    step("mid_pre", disp(4, 4));
    step("mid_pre", disp(4, 4));
    step("mid_idx5", disp(4, 5));
    step("mid_guard3", dark(5));
    step("mid_guard2", dark(5));
    rst      = 1'b1;
    scan_clk = 1'b0;
    step("mid_reset", dark(0));
    rst = 1'b0;
    step("mid_reset_release", disp(0, 0));
    scan_step("restart", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
